// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer in front of the
// single-ported data memory. Port C (core LSU) and port D (DMA/debug) share
// the memory. Each accepted request is captured, driven onto the memory for
// one ACCESS cycle, and answered with a one-cycle response pulse in RESP.
// Misaligned or illegal accesses never reach the memory and are answered
// with err=1, rdata=0.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   c_*/d_* req,we,addr,wdata,funct3   request fields per port
//   c_*/d_* gnt,rvalid,rdata,err       grant and response per port
//   mem_MemRead, mem_MemWrite, mem_a, mem_wd, mem_Funct3  memory side
//   mem_rd                        memory read data (combinational)
//
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, C always beats D
//   undefined -> round-robin using a last-grant register (resets to D)

module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    input  logic [2:0]            c_funct3,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_Funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  owner_d_q;   // 1 = port D owns the access in flight
    logic                  illegal_q;
    logic                  any_req;
    logic                  start;
    logic                  win_d;
    logic                  w_we;
    logic [DM_ADDRESS-1:0] w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic [2:0]            w_funct3;
    logic                  w_legal;
    logic [DATA_W-1:0]     resp_data;

    // Legality of a load/store: funct3 must be a supported encoding and the
    // address must be naturally aligned to the access size.
    function automatic logic access_legal(input logic we, input logic [1:0] a_lo,
                                          input logic [2:0] f3);
        logic f3_ok;
        logic aligned;
        if (we) f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
        case (f3[1:0])
            2'b01:   aligned = ~a_lo[0];
            2'b10:   aligned = (a_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return f3_ok && aligned;
    endfunction

    assign any_req = c_req | d_req;
    assign start   = ((state_q == IDLE) || (state_q == RESP)) && any_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // C always wins a tie.
    assign win_d = d_req & ~c_req;
`else
    logic last_d_q;   // 1 = D was granted last

    // Tie goes to whichever port was not granted last.
    assign win_d = d_req & (~c_req | ~last_d_q);

    // Last-grant register, updated at each arbitration point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_d_q <= 1'b1;
        else if (start) last_d_q <= win_d;
    end
`endif

    // Winner's request fields.
    assign w_we     = win_d ? d_we     : c_we;
    assign w_addr   = win_d ? d_addr   : c_addr;
    assign w_wdata  = win_d ? d_wdata  : c_wdata;
    assign w_funct3 = win_d ? d_funct3 : c_funct3;
    assign w_legal  = access_legal(w_we, w_addr[1:0], w_funct3);

    // Only a legal load drives MemRead, so this gates errors and stores to 0.
    assign resp_data = mem_MemRead ? mem_rd : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = any_req ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture, memory drive and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d_q    <= 1'b0;
            illegal_q    <= 1'b0;
            c_gnt        <= 1'b0;
            d_gnt        <= 1'b0;
            c_rvalid     <= 1'b0;
            d_rvalid     <= 1'b0;
            c_err        <= 1'b0;
            d_err        <= 1'b0;
            c_rdata      <= '0;
            d_rdata      <= '0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_a        <= '0;
            mem_wd       <= '0;
            mem_Funct3   <= 3'b000;
        end else begin
            c_gnt        <= 1'b0;
            d_gnt        <= 1'b0;
            c_rvalid     <= 1'b0;
            d_rvalid     <= 1'b0;
            c_err        <= 1'b0;
            d_err        <= 1'b0;
            c_rdata      <= '0;
            d_rdata      <= '0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            if (start) begin
                owner_d_q    <= win_d;
                illegal_q    <= ~w_legal;
                c_gnt        <= ~win_d;
                d_gnt        <= win_d;
                mem_a        <= w_addr;
                mem_wd       <= w_wdata;
                mem_Funct3   <= w_funct3;
                mem_MemRead  <= w_legal & ~w_we;
                mem_MemWrite <= w_legal & w_we;
            end
            if (state_q == ACCESS) begin
                if (owner_d_q) begin
                    d_rvalid <= 1'b1;
                    d_err    <= illegal_q;
                    d_rdata  <= resp_data;
                end else begin
                    c_rvalid <= 1'b1;
                    c_err    <= illegal_q;
                    c_rdata  <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural datamemory on the
// memory side plus a transaction-level reference model (byte array, legality
// rule, grant order) that predicts every response.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [8:0]  c_addr, d_addr;
    logic [31:0] c_wdata, d_wdata;
    logic [2:0]  c_funct3, d_funct3;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_MemRead, mem_MemWrite;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd, mem_rd;
    logic [2:0]  mem_Funct3;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_Funct3(mem_Funct3), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // ---------------- datamemory stand-in ----------------
    logic [7:0] dm [512];
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        b0 = dm[mem_a];
        b1 = dm[mem_a + 9'd1];
        b2 = dm[mem_a + 9'd2];
        b3 = dm[mem_a + 9'd3];
        case (mem_Funct3)
            3'b000:  mem_rd = {{24{b0[7]}}, b0};
            3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rd = {b3, b2, b1, b0};
            3'b100:  mem_rd = {24'h0, b0};
            3'b101:  mem_rd = {16'h0, b1, b0};
            default: mem_rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_MemWrite) begin
            dm[mem_a] <= mem_wd[7:0];
            if (mem_Funct3[1:0] != 2'b00) dm[mem_a + 9'd1] <= mem_wd[15:8];
            if (mem_Funct3[1]) begin
                dm[mem_a + 9'd2] <= mem_wd[23:16];
                dm[mem_a + 9'd3] <= mem_wd[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [512];
    bit         ref_last_d = 1'b1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit we, input logic [8:0] a, input logic [2:0] f3);
        bit ok;
        if (we) ok = f3 inside {3'd0, 3'd1, 3'd2};
        else    ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if (!ok) return 1'b0;
        return (int'(a) % size_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [2:0] f3);
        logic [31:0] v = 32'h0;
        int n = size_of(f3);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [8:0] a, input logic [2:0] f3, input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    // ---------------- driver ----------------
    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_funct3 = 3'b010;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_funct3 = 3'b010;
    endtask

    // Issue one access on port p (1 = D) starting at a negedge and observe it.
    task automatic issue(input bit p, input bit we, input logic [8:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output int gcyc, output int rcyc,
                         output logic [31:0] rd, output logic er, output bit stray,
                         output int nrd, output int nwr);
        gcyc = -1; rcyc = -1; rd = 32'h0; er = 1'b0; stray = 0; nrd = 0; nwr = 0;
        if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_funct3 = f3; end
        else   begin c_req = 1; c_we = we; c_addr = a; c_wdata = wd; c_funct3 = f3; end
        ref_last_d = p;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (mem_MemRead)  nrd++;
            if (mem_MemWrite) nwr++;
            if (p ? (c_gnt || c_rvalid) : (d_gnt || d_rvalid)) stray = 1;
            if (gcyc < 0 && (p ? d_gnt : c_gnt)) begin
                gcyc = cyc;
                c_req = 0; d_req = 0;
            end
            if (p ? d_rvalid : c_rvalid) begin
                rcyc = cyc;
                rd = p ? d_rdata : c_rdata;
                er = p ? d_err : c_err;
                break;
            end
        end
        c_req = 0; d_req = 0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_MemRead, mem_MemWrite} !== 8'h0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000000",
                {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_MemRead, mem_MemWrite});
        end
        checks++;
        if ({c_rdata, d_rdata, mem_wd, mem_a, mem_Funct3} !== 108'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {c_rdata, d_rdata, mem_wd, mem_a, mem_Funct3});
        end
        rst_n = 1;
        ref_last_d = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({c_gnt, d_gnt, c_rvalid, d_rvalid, mem_MemRead, mem_MemWrite} !== 6'h0) begin
            errors++; $display("FAIL idle_quiet got %b exp 000000",
                {c_gnt, d_gnt, c_rvalid, d_rvalid, mem_MemRead, mem_MemWrite});
        end
    endtask

    task automatic test_c_load();
        int g, r, nr, nw; logic [31:0] rd; logic er; bit st;
        issue(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, g, r, rd, er, st, nr, nw);
        ref_store(9'h010, 3'b010, 32'hDEADBEEF);
        checks++;
        if (g !== 1 || r !== 2 || nw !== 1 || er !== 1'b0) begin
            errors++; $display("FAIL c_store gnt %0d rv %0d wr %0d err %b exp 1 2 1 0", g, r, nw, er);
        end
        issue(0, 0, 9'h010, 32'h0, 3'b010, g, r, rd, er, st, nr, nw);
        checks++;
        if (g !== 1) begin errors++; $display("FAIL c_load_gnt_cycle got %0d exp 1", g); end
        checks++;
        if (r !== 2) begin errors++; $display("FAIL c_load_rvalid_cycle got %0d exp 2", r); end
        checks++;
        if (rd !== ref_load(9'h010, 3'b010) || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL c_load_rdata got %h exp deadbeef", rd);
        end
        checks++;
        if (er !== 1'b0 || st) begin errors++; $display("FAIL c_load_err got %b stray %0d exp 0 0", er, st); end
    endtask

    task automatic test_round_robin();
        int gcyc[$]; bit gport[$]; bit exp_p; bit last;
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 9'h020; c_funct3 = 3'b010;
        d_req = 1; d_we = 0; d_addr = 9'h024; d_funct3 = 3'b010;
        for (int cyc = 1; cyc <= 20 && gcyc.size() < 4; cyc++) begin
            @(negedge clk);
            if (c_gnt) begin gcyc.push_back(cyc); gport.push_back(1'b0); end
            if (d_gnt) begin gcyc.push_back(cyc); gport.push_back(1'b1); end
        end
        c_req = 0; d_req = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (gcyc.size() != 4) begin errors++; $display("FAIL rr_grant_count got %0d exp 4", gcyc.size()); end
        last = ref_last_d;
        for (int i = 0; i < gcyc.size() && i < 4; i++) begin
            exp_p = FIXED ? 1'b0 : ~last;
            last = exp_p;
            checks++;
            if (gport[i] !== exp_p) begin
                errors++; $display("FAIL rr_order[%0d] got %s exp %s", i, gport[i] ? "D" : "C", exp_p ? "D" : "C");
            end
            if (i > 0) begin
                checks++;
                if (gcyc[i] - gcyc[i-1] != 2) begin
                    errors++; $display("FAIL rr_spacing[%0d] got %0d exp 2", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
        ref_last_d = last;
    endtask

    task automatic test_misaligned();
        int g, r, nr, nw; logic [31:0] rd; logic er; bit st;
        issue(1, 0, 9'h013, 32'h0, 3'b010, g, r, rd, er, st, nr, nw);
        checks++;
        if (r !== 2 || er !== 1'b1) begin errors++; $display("FAIL misaligned_err rv %0d err %b exp 2 1", r, er); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_rdata got %h exp 0", rd); end
        checks++;
        if (nr !== 0 || st) begin errors++; $display("FAIL misaligned_memread got %0d stray %0d exp 0 0", nr, st); end
    endtask

    task automatic test_illegal_store();
        int g, r, nr, nw; logic [31:0] rd; logic er; bit st;
        issue(1, 1, 9'h040, 32'h12345678, 3'b100, g, r, rd, er, st, nr, nw);
        checks++;
        if (r !== 2 || er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL illegal_store rv %0d err %b rdata %h exp 2 1 0", r, er, rd);
        end
        checks++;
        if (nw !== 0) begin errors++; $display("FAIL illegal_store_memwrite got %0d exp 0", nw); end
    endtask

    task automatic test_back_to_back();
        int g[$]; int r[$]; logic [31:0] rd = 32'h0; int nw = 0, nr = 0;
        logic [31:0] wd = $urandom;
        @(negedge clk);
        c_req = 1; c_we = 1; c_addr = 9'h080; c_wdata = wd; c_funct3 = 3'b010;
        ref_last_d = 1'b0;
        for (int cyc = 1; cyc <= 10 && r.size() < 2; cyc++) begin
            @(negedge clk);
            if (mem_MemWrite) nw++;
            if (mem_MemRead) nr++;
            if (c_gnt) begin
                g.push_back(cyc);
                if (g.size() == 1) c_we = 0;   // new load request presented during RESP
                else c_req = 0;
            end
            if (c_rvalid) begin r.push_back(cyc); rd = c_rdata; end
        end
        c_req = 0;
        ref_store(9'h080, 3'b010, wd);
        repeat (2) @(negedge clk);
        checks++;
        if (g.size() != 2 || g[0] != 1 || g[1] != 3) begin
            errors++; $display("FAIL b2b_grants count %0d second %0d exp 2 3", g.size(), g.size() > 1 ? g[1] : -1);
        end
        checks++;
        if (r.size() != 2 || r[1] != 4) begin
            errors++; $display("FAIL b2b_rvalid count %0d last %0d exp 2 4", r.size(), r.size() > 1 ? r[1] : -1);
        end
        checks++;
        if (rd !== ref_load(9'h080, 3'b010) || nw != 1 || nr != 1) begin
            errors++; $display("FAIL b2b_data got %h wr %0d rd %0d exp %h 1 1", rd, nw, nr, ref_load(9'h080, 3'b010));
        end
    endtask

    task automatic test_random();
        int g, r, nr, nw; logic [31:0] rd, exp_rd, wd; logic er; bit st, p, we, leg;
        logic [8:0] a; logic [2:0] f3;
        for (int t = 0; t < 60; t++) begin
            p = 1'($urandom); we = 1'($urandom);
            f3 = 3'($urandom); wd = $urandom;
            a = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            leg = ref_legal(we, a, f3);
            exp_rd = (leg && !we) ? ref_load(a, f3) : 32'h0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(p, we, a, wd, f3, g, r, rd, er, st, nr, nw);
            if (leg && we) ref_store(a, f3, wd);
            checks++;
            if (g !== 1 || r !== 2 || st) begin
                errors++; $display("FAIL rand_timing[%0d] gnt %0d rv %0d stray %0d exp 1 2 0", t, g, r, st);
            end
            checks++;
            if (er !== !leg || rd !== exp_rd) begin
                errors++; $display("FAIL rand_resp[%0d] we %0d a %h f3 %0d err %b rdata %h exp %b %h",
                                   t, we, a, f3, er, rd, !leg, exp_rd);
            end
            checks++;
            if (nr != int'(leg && !we) || nw != int'(leg && we)) begin
                errors++; $display("FAIL rand_mem[%0d] rd %0d wr %0d exp %0d %0d", t, nr, nw, leg && !we, leg && we);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_rv = 0;
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 9'h040; d_funct3 = 3'b010;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || mem_MemRead !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre gnt %b memread %b exp 1 1", d_gnt, mem_MemRead);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (mem_MemRead !== 1'b0 || d_gnt !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async memread %b gnt %b exp 0 0", mem_MemRead, d_gnt);
        end
        d_req = 0;
        repeat (3) begin @(negedge clk); if (d_rvalid) seen_rv = 1; end
        rst_n = 1;
        ref_last_d = 1'b1;
        @(negedge clk);
        if (d_rvalid) seen_rv = 1;
        checks++;
        if (seen_rv) begin errors++; $display("FAIL rst_mid_rvalid got 1 exp 0"); end
        checks++;
        if ({c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_MemRead, mem_MemWrite} !== 8'h0 ||
            {c_rdata, d_rdata} !== 64'h0) begin
            errors++; $display("FAIL rst_mid_outputs got %b exp 00000000",
                {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_MemRead, mem_MemWrite});
        end
        // Last-grant is back to D, so a tie goes to C in either mode.
        c_req = 1; c_we = 0; c_addr = 9'h000; c_funct3 = 3'b010;
        d_req = 1; d_we = 0; d_addr = 9'h004; d_funct3 = 3'b010;
        @(negedge clk);
        checks++;
        if ({c_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL rst_mid_tie got %b exp 10", {c_gnt, d_gnt}); end
        c_req = 0; d_req = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin dm[i] = 8'h0; ref_mem[i] = 8'h0; end
        test_reset();
        test_c_load();
        test_round_robin();
        test_misaligned();
        test_illegal_store();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
